div: RTL and testbench
======================

Name: div

Overview:
Multi-cycle 32-bit signed/unsigned integer divider. It is the responder end of the divide handshake that the EX stage initiates.
- Accepts dividend, divisor and signedness with a start request, then iterates one restoring-division step per clock.
- Returns {remainder, quotient} with a ready flag.
- Sits beside EX: EX stalls the pipeline until ready, then writes HI = remainder and LO = quotient.

Parameters:
none: all widths come from RegBus (32) and DoubleRegBus (64) in defines.v.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-high (RstEnable = 1'b1)
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU)
opdata1_i  input  32  dividend
opdata2_i  input  32  divisor
start_i  input  1  DivStart (1) requests or holds an operation; DivStop (0) releases it
annul_i  input  1  flush; aborts any in-flight operation
result_o  output  64  [63:32] remainder, [31:0] quotient
ready_o  output  1  DivResultReady (1) when result_o is valid

Behaviour:
Reset (async, any state):
- state = DivFree, cnt = 0, dividend register = 0, divisor register = 0.
- result_o = 0, ready_o = DivResultNotReady (0).

States (2-bit, from defines.v): DivFree, DivByZero, DivOn, DivEnd.

DivFree:
- If start_i = 1 and annul_i = 0:
  - divisor = 0 → DivByZero.
  - Otherwise → DivOn, with cnt = 0.
    - Operands are latched this edge. If signed_div_i = 1, each negative operand is replaced by its two's-complement magnitude.
    - dividend register = {32'b0, |dividend|}; divisor register = |divisor|.
- Otherwise stay in DivFree. ready_o = 0, result_o = 0.

DivByZero:
- Next edge → DivEnd with dividend register = 0, so the result is 0.

DivOn:
- If annul_i = 1 → DivFree at the next edge, no result, ready_o stays 0.
- Else if cnt < 32, perform one restoring step:
  - diff = {1'b0, dividend[63:31]} − {1'b0, divisor}.
  - diff[32] = 1: dividend = {dividend[62:0], 1'b0}.
  - diff[32] = 0: dividend = {diff[31:0], dividend[30:0], 1'b1}.
  - cnt = cnt + 1.
- Else (cnt = 32):
  - If signed and sign(op1) ≠ sign(op2), negate the quotient.
  - If signed and op1 is negative, negate the remainder.
  - → DivEnd.
  - Original operand signs are taken from values latched at acceptance, not from live inputs.

DivEnd:
- result_o = {remainder, quotient}, ready_o = 1.
- If start_i = 0 → DivFree, with ready_o = 0 and result_o = 0 after that edge.
- If start_i = 1, hold the result (ready_o stays 1).

Latency:
- start sampled high at edge 0. ready_o is high after edge 33 (32 steps plus a fixup edge).
- Divide-by-zero: ready_o is high after edge 1.

Other rules:
- Live operand changes during DivOn are ignored.
- A new request is accepted only from DivFree.
- 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0 (wraps, no trap).
- annul_i in DivFree, DivByZero or DivEnd has no special effect beyond blocking acceptance in DivFree.
- Outputs are registered: no combinational path from inputs to outputs.

Decomposition:
- defines.v (shared with EX) holds:
  - DivFree/DivByZero/DivOn/DivEnd encodings.
  - DivResultReady/DivResultNotReady, DivStart/DivStop.
  - RegBus, DoubleRegBus, ZeroWord.
- Single module. The restoring step is a few lines and needs no sub-module.
- A checker-side reference model belongs in the bench only.

Test Plan:
- Unsigned: 100 / 7, signed_div_i = 0, start held until ready.
  → after edge 33, result_o = {0x00000002, 0x0000000E}, ready_o = 1.
  → drop start: ready_o = 0 and result_o = 0 next cycle.
- Signed sign combinations:
  - 7 / −2 → {0x00000001, 0xFFFFFFFD}.
  - −7 / 2 → {0xFFFFFFFF, 0xFFFFFFFD}.
  - −7 / −2 → {0xFFFFFFFF, 0x00000003}.
- Divide by zero: 0x12345678 / 0, signed.
  → ready_o high after edge 1, result_o = 0.
- Overflow corner: signed 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}.
  Also unsigned 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- Annul: assert annul_i at cnt = 10.
  → DivFree, ready_o never rises.
  → A fresh 9 / 3 request right after returns {0, 3} with full 33-edge latency.
- Reset: assert rst asynchronously mid-DivOn and mid-DivEnd.
  → ready_o and result_o go to 0 immediately, without waiting for a clock edge.
  → Operand changes during DivOn do not alter the result (compare against latched-operand model).

Source files
------------

// File: rtl/div_pkg.sv
// Purpose : shared constants for the EX-side divide handshake and the restoring step helpers.
// Latency : n/a (constants and pure functions only).
// Backpressure: n/a.
package div_pkg;

    // Bus widths shared with EX.
    localparam int REG_BUS        = 32;
    localparam int DOUBLE_REG_BUS = 64;
    localparam logic [REG_BUS-1:0] ZERO_WORD = 32'h0000_0000;

    // Divider FSM encodings (must stay identical to the EX-side copies).
    localparam logic [1:0] DIV_FREE    = 2'b00;
    localparam logic [1:0] DIV_BY_ZERO = 2'b01;
    localparam logic [1:0] DIV_ON      = 2'b10;
    localparam logic [1:0] DIV_END     = 2'b11;

    // Handshake levels.
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    // Magnitude of an operand; only negative values of a signed divide are flipped.
    function automatic logic [REG_BUS-1:0] op_mag(input logic [REG_BUS-1:0] v,
                                                  input logic            is_signed);
        return (is_signed && v[REG_BUS-1]) ? (~v + 32'd1) : v;
    endfunction

    // One restoring-division step. The partial remainder lives in [63:32], the
    // not-yet-consumed dividend bits in [31:0]; quotient bits shift in at bit 0.
    function automatic logic [DOUBLE_REG_BUS-1:0] restore_step(
            input logic [DOUBLE_REG_BUS-1:0] dvd,
            input logic [REG_BUS-1:0]        dvs);
        logic [REG_BUS:0] diff;
        diff = dvd[63:31] - {1'b0, dvs};
        // diff[32] set means the trial subtraction went negative: restore.
        if (diff[REG_BUS])
            return {dvd[62:0], 1'b0};
        else
            return {diff[31:0], dvd[30:0], 1'b1};
    endfunction

endpackage

// File: rtl/div.sv
// Purpose : multi-cycle 32-bit signed/unsigned restoring divider answering the EX divide request.
// Latency : ready_o rises 33 edges after start is accepted (1 edge for divide-by-zero).
// Backpressure: result is held while start_i stays high; dropping start_i releases it.
//
// Ports:
//   clk          pipeline clock, rising edge
//   rst          asynchronous active-high reset
//   signed_div_i 1 = signed divide, 0 = unsigned
//   opdata1_i    dividend (sampled only on acceptance)
//   opdata2_i    divisor  (sampled only on acceptance)
//   start_i      1 requests / holds an operation, 0 releases it
//   annul_i      flush; aborts an in-flight divide and blocks acceptance
//   result_o     {remainder, quotient}, registered
//   ready_o      result_o valid, registered
module div
    import div_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      signed_div_i,
    input  logic [REG_BUS-1:0]        opdata1_i,
    input  logic [REG_BUS-1:0]        opdata2_i,
    input  logic                      start_i,
    input  logic                      annul_i,
    output logic [DOUBLE_REG_BUS-1:0] result_o,
    output logic                      ready_o
);

    logic [1:0]                state_q,    state_d;
    logic [5:0]                cnt_q,      cnt_d;
    logic [DOUBLE_REG_BUS-1:0] dividend_q, dividend_d;
    logic [REG_BUS-1:0]        divisor_q,  divisor_d;
    logic                      op1_neg_q,  op1_neg_d;
    logic                      op2_neg_q,  op2_neg_d;
    logic [DOUBLE_REG_BUS-1:0] result_q,   result_d;
    logic                      ready_q,    ready_d;

    logic [REG_BUS-1:0] quo_fix;
    logic [REG_BUS-1:0] rem_fix;

    // Sign fixup uses the operand signs captured at acceptance, never the live inputs.
    always_comb begin
        quo_fix = (op1_neg_q ^ op2_neg_q) ? (~dividend_q[31:0] + 32'd1) : dividend_q[31:0];
        rem_fix = op1_neg_q ? (~dividend_q[63:32] + 32'd1) : dividend_q[63:32];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        op1_neg_d  = op1_neg_q;
        op2_neg_d  = op2_neg_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            DIV_FREE: begin
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == ZERO_WORD) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        state_d    = DIV_ON;
                        cnt_d      = 6'd0;
                        dividend_d = {ZERO_WORD, op_mag(opdata1_i, signed_div_i)};
                        divisor_d  = op_mag(opdata2_i, signed_div_i);
                        op1_neg_d  = signed_div_i & opdata1_i[REG_BUS-1];
                        op2_neg_d  = signed_div_i & opdata2_i[REG_BUS-1];
                    end
                end
            end

            DIV_BY_ZERO: begin
                // Divide-by-zero reports a zero result rather than trapping.
                state_d    = DIV_END;
                dividend_d = '0;
                result_d   = '0;
                ready_d    = DIV_RESULT_READY;
            end

            DIV_ON: begin
                if (annul_i) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end else if (cnt_q < 6'd32) begin
                    dividend_d = restore_step(dividend_q, divisor_q);
                    cnt_d      = cnt_q + 6'd1;
                end else begin
                    state_d    = DIV_END;
                    dividend_d = {rem_fix, quo_fix};
                    result_d   = {rem_fix, quo_fix};
                    ready_d    = DIV_RESULT_READY;
                end
            end

            DIV_END: begin
                result_d = dividend_q;
                ready_d  = DIV_RESULT_READY;
                if (start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end
            end

            default: begin
                state_d  = DIV_FREE;
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= 6'd0;
            dividend_q <= '0;
            divisor_q  <= '0;
            op1_neg_q  <= 1'b0;
            op2_neg_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DIV_RESULT_NOT_READY;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            op1_neg_q  <= op1_neg_d;
            op2_neg_q  <= op2_neg_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Purpose : self-checking bench for the restoring divider (vector table + random ops + corner sequences).
// Latency : checks 33-edge (1-edge for divide-by-zero) result latency.
// Backpressure: holds start_i to keep the result, then releases it.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    // Reference model: 64-bit integer division, truncating toward zero.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'h0) return 64'h0;
        sa = s ? longint'($signed(a)) : longint'({32'h0, a});
        sb = s ? longint'($signed(b)) : longint'({32'h0, b});
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Waits at negedges for ready_o; live operands are scrambled meanwhile.
    task automatic wait_ready(output int lat);
        lat = 0;
        @(negedge clk);
        while (!ready_o && lat < 100) begin
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = ~signed_div_i;
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic pop_check(input string name);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_queue"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check(name, result_o, e);
        end
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input string name);
        int lat;
        int exp_lat;
        exp_lat = (b == 32'h0) ? 1 : 33;
        @(negedge clk);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        exp_q.push_back(exp);
        wait_ready(lat);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        pop_check({name, "_result"});
        // Holding start keeps the result.
        @(negedge clk);
        check({name, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
        check({name, "_hold_result"}, result_o, exp);
        start_i = 1'b0;
        @(negedge clk);
        check({name, "_drop_ready"}, {63'd0, ready_o}, 64'd0);
        check({name, "_drop_result"}, result_o, 64'd0);
    endtask

    initial begin
        int lat;
        logic seen;
        logic [31:0] ra, rb;
        logic rs;

        vecs[0]  = '{32'd100,       32'd7,         1'b0, {32'h0000_0002, 32'h0000_000E}};
        vecs[1]  = '{32'd7,         32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}};
        vecs[2]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
        vecs[3]  = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, {32'hFFFF_FFFF, 32'h0000_0003}};
        vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}};
        vecs[5]  = '{32'hFFFF_FFFF, 32'd1,         1'b0, {32'h0000_0000, 32'hFFFF_FFFF}};
        vecs[6]  = '{32'h1234_5678, 32'd0,         1'b1, 64'h0};
        vecs[7]  = '{32'd9,         32'd3,         1'b0, {32'h0000_0000, 32'h0000_0003}};
        vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'h0000_0000, 32'h0000_0001}};
        vecs[9]  = '{32'hFFFF_FFF9, 32'd2,         1'b0, {32'h0000_0001, 32'h7FFF_FFFC}};
        vecs[10] = '{32'd5,         32'd10,        1'b0, {32'h0000_0005, 32'h0000_0000}};

        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'h0;
        opdata2_i    = 32'h0;
        #2;
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++)
            do_div(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            if (i % 4 == 1) rb = ~rb;
            rs = i[0];
            do_div(ra, rb, rs, model(ra, rb, rs), $sformatf("rand%0d", i));
        end

        // Annul at cnt = 10: no result, then a fresh request runs full latency.
        @(negedge clk);
        opdata1_i = 32'd20; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
        seen = 1'b0;
        repeat (11) begin
            @(negedge clk);
            if (ready_o) seen = 1'b1;
        end
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen = 1'b1;
        end
        check("annul_no_ready", {63'd0, seen}, 64'd0);
        do_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, "after_annul");

        // Async reset mid-DivOn.
        @(negedge clk);
        opdata1_i = 32'd1000; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_on_ready", {63'd0, ready_o}, 64'd0);
        check("rst_on_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen = 1'b1;
        end
        check("rst_on_no_ready", {63'd0, seen}, 64'd0);

        // Async reset mid-DivEnd: outputs must clear without a clock edge.
        @(negedge clk);
        opdata1_i = 32'hFFFF_FF9C; opdata2_i = 32'd7; signed_div_i = 1'b1; start_i = 1'b1;
        exp_q.push_back(model(32'hFFFF_FF9C, 32'd7, 1'b1));
        wait_ready(lat);
        check("rst_end_latency", 64'(lat), 64'd33);
        pop_check("rst_end_result");
        #2 rst = 1'b1;
        #1;
        check("rst_end_ready", {63'd0, ready_o}, 64'd0);
        check("rst_end_result_clr", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_div(32'd77, 32'd5, 1'b0, {32'd2, 32'd15}, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
